// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses A5-framed register read/write commands from
// uart_rx, executes them against a 16 x 8-bit register file and returns a
// two-byte response through uart_tx.
module uart_cmd_responder #(
    parameter int BYTE_W         = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  valid,
    input  logic                  parity_error,
    input  logic                  tx_busy,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  wr_en,
    output logic [16*BYTE_W-1:0]  regs,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [BYTE_W-1:0] HDR     = BYTE_W'(8'hA5);
    localparam logic [BYTE_W-1:0] RSP_OK  = BYTE_W'(8'h5A);
    localparam logic [BYTE_W-1:0] RSP_ERR = BYTE_W'(8'hEE);
    localparam logic [BYTE_W-1:0] CODE_PE = BYTE_W'(8'h01);
    localparam logic [BYTE_W-1:0] CODE_BC = BYTE_W'(8'h02);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_DATA, S_EXEC, S_ERR, S_TX0, S_W0, S_TX1, S_W1
    } state_t;

    state_t                        state_q, state_d;
    logic [3:0]                    addr_q, addr_d;
    logic                          is_wr_q, is_wr_d;
    logic [BYTE_W-1:0]             wdat_q, wdat_d;
    logic [BYTE_W-1:0]             resp1_q, resp1_d;   // second response byte (data or error code)
    logic [BYTE_W-1:0]             tx_data_q, tx_data_d;
    logic [15:0][BYTE_W-1:0]       regs_q, regs_d;
    logic [7:0]                    drop_q, drop_d;
    logic [TO_W-1:0]               tmo_q, tmo_d;
    logic                          guard_q, guard_d;   // first cycle of W0/W1, before tx_busy is meaningful
    logic                          wr_en_c;
    logic                          in_resp;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            is_wr_q   <= 1'b0;
            wdat_q    <= '0;
            resp1_q   <= '0;
            tx_data_q <= '0;
            regs_q    <= '0;
            drop_q    <= '0;
            tmo_q     <= '0;
            guard_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            is_wr_q   <= is_wr_d;
            wdat_q    <= wdat_d;
            resp1_q   <= resp1_d;
            tx_data_q <= tx_data_d;
            regs_q    <= regs_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
            guard_q   <= guard_d;
        end
    end

    // Next-state, frame parsing, execution and response sequencing
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        is_wr_d   = is_wr_q;
        wdat_d    = wdat_q;
        resp1_d   = resp1_q;
        tx_data_d = tx_data_q;
        regs_d    = regs_q;
        tmo_d     = tmo_q;
        guard_d   = guard_q;
        wr_en_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (valid && !parity_error && rx_data == HDR)
                    state_d = S_CMD;
            end
            S_CMD: begin
                tmo_d = tmo_q + TO_W'(1);
                if (valid) begin
                    tmo_d = '0;
                    if (parity_error) begin
                        resp1_d = CODE_PE;
                        state_d = S_ERR;
                    end else if (rx_data[6:4] != 3'b000) begin
                        resp1_d = CODE_BC;
                        state_d = S_ERR;
                    end else begin
                        addr_d  = rx_data[3:0];
                        is_wr_d = rx_data[7];
                        state_d = rx_data[7] ? S_DATA : S_EXEC;
                    end
                end else if (tmo_q == TO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                tmo_d = tmo_q + TO_W'(1);
                if (valid) begin
                    tmo_d = '0;
                    if (parity_error) begin
                        resp1_d = CODE_PE;
                        state_d = S_ERR;
                    end else begin
                        wdat_d  = rx_data;
                        state_d = S_EXEC;
                    end
                end else if (tmo_q == TO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (is_wr_q) regs_d[addr_q] = wdat_q;
                tx_data_d = RSP_OK;
                resp1_d   = is_wr_q ? '0 : regs_q[addr_q];
                state_d   = S_TX0;
            end
            S_ERR: begin
                tx_data_d = RSP_ERR;
                state_d   = S_TX0;
            end
            S_TX0: begin
                if (!tx_busy) begin
                    wr_en_c = 1'b1;
                    guard_d = 1'b1;
                    state_d = S_W0;
                end
            end
            S_W0: begin
                // tx_data only changes here, after uart_tx has taken byte 0
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!tx_busy) begin
                    tx_data_d = resp1_q;
                    state_d   = S_TX1;
                end
            end
            S_TX1: begin
                if (!tx_busy) begin
                    wr_en_c = 1'b1;
                    guard_d = 1'b1;
                    state_d = S_W1;
                end
            end
            S_W1: begin
                if (guard_q) guard_d = 1'b0;
                else if (!tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bytes arriving while a command executes or responds are dropped and counted
    always_comb begin
        in_resp = (state_q == S_EXEC) || (state_q == S_ERR) || (state_q == S_TX0) ||
                  (state_q == S_W0)   || (state_q == S_TX1) || (state_q == S_W1);
        drop_d  = drop_q;
        if (valid && in_resp && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
    end

    // wr_en is gated by rst so a reset mid-response never emits another strobe
    assign wr_en    = wr_en_c & ~rst;
    assign tx_data  = tx_data_q;
    assign regs     = regs_q;
    assign busy     = (state_q != S_IDLE);
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed plan scenarios plus
// randomized frames compared against a frame-level register model.
module tb_uart_cmd_responder;
    localparam int TO = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         valid = 1'b0;
    logic         parity_error = 1'b0;
    logic         tx_busy;
    logic [7:0]   tx_data;
    logic         wr_en;
    logic [127:0] regs;
    logic         busy;
    logic [7:0]   drop_cnt;

    uart_cmd_responder #(.BYTE_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .valid(valid),
        .parity_error(parity_error), .tx_busy(tx_busy), .tx_data(tx_data),
        .wr_en(wr_en), .regs(regs), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc = 0;

    // reference model state
    logic [7:0] mregs [16];
    int         mdrop = 0;

    // uart_tx model: busy for busy_len cycles starting the cycle after wr_en
    int busy_len = 4;
    int bcnt     = 0;
    assign tx_busy = (bcnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) bcnt <= busy_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    // capture transmitted bytes and check strobe rules, sampled mid-cycle
    logic [7:0] txq [$];
    int         wrcyc [$];
    logic       prev_wr = 1'b0;
    always @(negedge clk) begin
        if (wr_en) begin
            checks++;
            if (tx_busy !== 1'b0 || prev_wr !== 1'b0) begin
                errors++;
                $display("FAIL wr_en_rule tx_busy=%b prev_wr=%b, required 0 and 0", tx_busy, prev_wr);
            end
            txq.push_back(tx_data);
            wrcyc.push_back(cyc);
        end
        prev_wr = wr_en;
    end

    task automatic send_byte(input logic [7:0] b, input logic pe);
        @(negedge clk);
        last_acc     = cyc;
        rx_data      = b;
        parity_error = pe;
        valid        = 1'b1;
        @(negedge clk);
        valid        = 1'b0;
        parity_error = 1'b0;
    endtask

    task automatic wait_resp(output logic [7:0] b0, output logic [7:0] b1,
                             output int c0, output int c1);
        int n = 0;
        while (!(txq.size() >= 2 && busy === 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL resp_wait got %0d bytes busy=%b, required 2 bytes and idle", txq.size(), busy);
            b0 = 8'h00; b1 = 8'h00; c0 = 0; c1 = 0;
            txq.delete(); wrcyc.delete();
        end else begin
            b0 = txq.pop_front(); b1 = txq.pop_front();
            c0 = wrcyc.pop_front(); c1 = wrcyc.pop_front();
            checks++;
            if (txq.size() != 0) begin
                errors++;
                $display("FAIL resp_extra %0d extra bytes, required 0", txq.size());
                txq.delete(); wrcyc.delete();
            end
        end
    endtask

    task automatic wait_bytes(input int k);
        int n = 0;
        while (txq.size() < k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL byte_wait got %0d bytes, required %0d", txq.size(), k);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = mregs[k];
        return v;
    endfunction

    task automatic check_state(input string name);
        checks++;
        if (regs !== model_vec()) begin
            errors++;
            $display("FAIL %s_regs got %h, required %h", name, regs, model_vec());
        end
        checks++;
        if (drop_cnt !== mdrop[7:0]) begin
            errors++;
            $display("FAIL %s_drop got %0d, required %0d", name, drop_cnt, mdrop);
        end
    endtask

    task automatic check_resp(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] e0, input logic [7:0] e1);
        checks++;
        if ({b0, b1} !== {e0, e1}) begin
            errors++;
            $display("FAIL %s_resp got %h %h, required %h %h", name, b0, b1, e0, e1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_en, busy, tx_data, drop_cnt, regs} !== '0) begin
            errors++;
            $display("FAIL reset_outputs wr_en=%b busy=%b tx_data=%h drop=%h regs=%h, required all 0",
                     wr_en, busy, tx_data, drop_cnt, regs);
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        mdrop = 0;
    endtask

    task automatic test_write_read();
        logic [7:0] b0, b1; int c0, c1, acc;
        busy_len = 3;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h83, 1'b0);
        send_byte(8'h3C, 1'b0);
        acc = last_acc;
        checks++;
        if (regs[31:24] !== 8'h00) begin
            errors++;
            $display("FAIL wr_early reg3 got %h at N+1, required 00", regs[31:24]);
        end
        @(negedge clk);
        checks++;
        if (regs[31:24] !== 8'h3C) begin
            errors++;
            $display("FAIL wr_visible reg3 got %h at N+2, required 3c", regs[31:24]);
        end
        mregs[3] = 8'h3C;
        wait_resp(b0, b1, c0, c1);
        check_resp("write", b0, b1, 8'h5A, 8'h00);
        checks++;
        if (c0 != acc + 2) begin
            errors++;
            $display("FAIL first_wr_latency got cycle %0d, required %0d", c0, acc + 2);
        end
        checks++;
        if (c1 < c0 + busy_len + 2) begin
            errors++;
            $display("FAIL second_wr_spacing got cycle %0d, required >= %0d", c1, c0 + busy_len + 2);
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        wait_resp(b0, b1, c0, c1);
        check_resp("read", b0, b1, 8'h5A, 8'h3C);
        check_state("write_read");
    endtask

    task automatic test_bad_cmd();
        logic [7:0] b0, b1; int c0, c1;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h13, 1'b0);
        wait_resp(b0, b1, c0, c1);
        check_resp("bad_cmd", b0, b1, 8'hEE, 8'h02);
        check_state("bad_cmd");
    endtask

    task automatic test_parity_data();
        logic [7:0] b0, b1; int c0, c1;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h85, 1'b0);
        send_byte(8'hFF, 1'b1);
        wait_resp(b0, b1, c0, c1);
        check_resp("parity_data", b0, b1, 8'hEE, 8'h01);
        check_state("parity_data");
    endtask

    task automatic test_timeout();
        logic [7:0] b0, b1; int c0, c1;
        send_byte(8'hA5, 1'b0);
        repeat (TO - 1) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early busy got %b, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || txq.size() != 0) begin
            errors++;
            $display("FAIL timeout_fire busy=%b bytes=%0d, required 0 and 0", busy, txq.size());
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_resp(b0, b1, c0, c1);
        check_resp("after_timeout", b0, b1, 8'h5A, mregs[0]);
    endtask

    task automatic test_overrun();
        logic [7:0] b0, b1; int c0, c1;
        // garbage in IDLE is not counted
        send_byte(8'h11, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b0);
        check_state("idle_garbage");
        busy_len = 20;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        wait_bytes(1);
        for (int i = 0; i < 3; i++) send_byte(8'hA5, 1'b0);
        mdrop += 3;
        wait_resp(b0, b1, c0, c1);
        check_resp("overrun", b0, b1, 8'h5A, mregs[3]);
        check_state("overrun");
        busy_len = 4;
    endtask

    task automatic test_random();
        logic [7:0] b0, b1, e0, e1, cmd, d, g;
        logic [3:0] a;
        logic [2:0] bits;
        logic       w;
        int c0, c1, kind;
        for (int it = 0; it < 30; it++) begin
            busy_len = $urandom_range(1, 6);
            if ($urandom_range(0, 2) == 0) begin
                g = $urandom;
                send_byte(g, (g == 8'hA5));
            end
            kind = $urandom_range(0, 4);
            a = $urandom; d = $urandom; bits = $urandom_range(1, 7); w = $urandom;
            send_byte(8'hA5, 1'b0);
            case (kind)
                0: begin
                    send_byte({4'h0, a}, 1'b0);
                    e0 = 8'h5A; e1 = mregs[a];
                end
                1: begin
                    send_byte({4'h8, a}, 1'b0);
                    send_byte(d, 1'b0);
                    mregs[a] = d;
                    e0 = 8'h5A; e1 = 8'h00;
                end
                2: begin
                    cmd = {w, bits, a};
                    send_byte(cmd, 1'b0);
                    e0 = 8'hEE; e1 = 8'h02;
                end
                3: begin
                    cmd = $urandom;
                    send_byte(cmd, 1'b1);
                    e0 = 8'hEE; e1 = 8'h01;
                end
                default: begin
                    send_byte({4'h8, a}, 1'b0);
                    send_byte(d, 1'b1);
                    e0 = 8'hEE; e1 = 8'h01;
                end
            endcase
            wait_resp(b0, b1, c0, c1);
            check_resp("random", b0, b1, e0, e1);
            check_state("random");
        end
    endtask

    task automatic test_reset_mid();
        busy_len = 10;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        wait_bytes(1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        mdrop = 0;
        repeat (40) @(negedge clk);
        checks++;
        if (txq.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_wr got %0d bytes, required 1", txq.size());
        end
        txq.delete(); wrcyc.delete();
        checks++;
        if (tx_data !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_out tx_data=%h busy=%b, required 00 and 0", tx_data, busy);
        end
        check_state("reset_mid");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bad_cmd();
        test_parity_data();
        test_timeout();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
